// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the EX-stage forwarding and hazard logic.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } pipe_tag_t;

endpackage

// File: rtl/fwd_tag_stage.sv
// One destination-tag pipeline register: holds on freeze, loads a bubble on clear.
module fwd_tag_stage import cpu_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      clear,
  input  pipe_tag_t d,
  output pipe_tag_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= clear ? '0 : d;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Producer side of EX-stage forwarding: tracks in-flight destination tags, registers
// operand selects at the ID->EX boundary and stalls ID on a load-use dependency.
module fwd_hazard_ctrl import cpu_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic [DATA_W-1:0] MEM_faddress,
  output logic [DATA_W-1:0] WB_fdata,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_write,
  output logic              hazard_stall
);

  function automatic logic match_tag(input pipe_tag_t t, input logic [REG_AW-1:0] s);
    return t.valid && t.reg_write && (t.rd == s) && (s != '0);
  endfunction

  pipe_tag_t id_tag;
  pipe_tag_t tag_p0;
  pipe_tag_t tag_p1;
  pipe_tag_t tag_p2;

  logic              ex_hit_a;
  logic              ex_hit_b;
  logic              bubble;
  logic [1:0]        fwd_a_nxt;
  logic [1:0]        fwd_b_nxt;
  logic [1:0]        fwd_a_p0;
  logic [1:0]        fwd_b_p0;
  logic [DATA_W-1:0] faddr_p1;
  logic [DATA_W-1:0] wb_data_p2;
  logic              unused_wb_mem_read;

  assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  assign ex_hit_a     = id_rs_used && match_tag(tag_p0, id_rs);
  assign ex_hit_b     = id_rt_used && match_tag(tag_p0, id_rt);
  // A load still in EX has no data yet; flush takes precedence since the consumer dies anyway.
  assign hazard_stall = id_valid && !flush && tag_p0.mem_read && (ex_hit_a || ex_hit_b);
  assign bubble       = flush || hazard_stall;

  always_comb begin
    fwd_a_nxt = FWD_NONE;
    fwd_b_nxt = FWD_NONE;
    if (!bubble) begin
      if (ex_hit_a)                                  fwd_a_nxt = FWD_MEM;
      else if (id_rs_used && match_tag(tag_p1, id_rs)) fwd_a_nxt = FWD_WB;
      if (ex_hit_b)                                  fwd_b_nxt = FWD_MEM;
      else if (id_rt_used && match_tag(tag_p1, id_rt)) fwd_b_nxt = FWD_WB;
    end
  end

  // ID -> EX
  fwd_tag_stage u_tag_ex (
    .clk(clk), .rst(rst), .hold(stall_in), .clear(bubble), .d(id_tag), .q(tag_p0)
  );

  // EX -> MEM
  fwd_tag_stage u_tag_mem (
    .clk(clk), .rst(rst), .hold(stall_in), .clear(1'b0), .d(tag_p0), .q(tag_p1)
  );

  // MEM -> WB
  fwd_tag_stage u_tag_wb (
    .clk(clk), .rst(rst), .hold(stall_in), .clear(1'b0), .d(tag_p1), .q(tag_p2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_p0   <= FWD_NONE;
      fwd_b_p0   <= FWD_NONE;
      faddr_p1   <= '0;
      wb_data_p2 <= '0;
    end else if (!stall_in) begin
      fwd_a_p0   <= fwd_a_nxt;
      fwd_b_p0   <= fwd_b_nxt;
      faddr_p1   <= ex_alu_out;
      wb_data_p2 <= tag_p1.mem_read ? mem_rdata : faddr_p1;
    end
  end

  assign ForwardA           = fwd_a_p0;
  assign ForwardB           = fwd_b_p0;
  assign MEM_faddress       = faddr_p1;
  assign WB_fdata           = wb_data_p2;
  assign wb_rd              = tag_p2.rd;
  assign wb_write           = tag_p2.valid && tag_p2.reg_write && (tag_p2.rd != '0);
  assign unused_wb_mem_read = tag_p2.mem_read;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl: expected values queued at drive time, popped at sample time.
module tb_fwd_hazard_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush;
  logic        id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic [15:0] ex_alu_out, mem_rdata;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] MEM_faddress, WB_fdata;
  logic [3:0]  wb_rd;
  logic        wb_write, hazard_stall;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  fwd_hazard_ctrl #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_alu_out(ex_alu_out), .mem_rdata(mem_rdata),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .MEM_faddress(MEM_faddress), .WB_fdata(WB_fdata),
    .wb_rd(wb_rd), .wb_write(wb_write), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic ru, input logic tu, input logic [3:0] rd,
                       input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain_pipe();
    nop(); ex_alu_out = '0; mem_rdata = '0; flush = 1'b0; stall_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst = 1'b1; stall_in = 1'b1; flush = 1'b0; nop();
    ex_alu_out = 16'hFFFF; mem_rdata = 16'hFFFF;
    sb.push_back(16'(FWD_NONE)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'h0);
    sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
    tick(); tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL reset_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL reset_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL reset_faddr got=%h exp=%h", MEM_faddress, e); end
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL reset_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL reset_wbwrite got=%b exp=%b", wb_write, e[0]); end
    e = sb.pop_front(); checks++; if (hazard_stall !== e[0]) begin failures++; $display("FAIL reset_hazard got=%b exp=%b", hazard_stall, e[0]); end
    rst = 1'b0; stall_in = 1'b0; ex_alu_out = '0; mem_rdata = '0;
  endtask

  task automatic test_fwd_mem();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd2, 1, 1, 4'd3, 1, 0);            // ADD R3,R1,R2
    tick();
    ex_alu_out = 16'h1234;
    drive(1, 4'd3, 4'd5, 1, 1, 4'd4, 1, 0);            // SUB R4,R3,R5
    sb.push_back(16'(FWD_MEM)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'h1234);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL mem_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL mem_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL mem_faddr got=%h exp=%h", MEM_faddress, e); end
    ex_alu_out = 16'h0F0F; nop();
    sb.push_back(16'h1234); sb.push_back(16'h1); sb.push_back(16'h3);
    tick();
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL mem_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL mem_wbwrite got=%b exp=%b", wb_write, e[0]); end
    e = sb.pop_front(); checks++; if (wb_rd !== e[3:0]) begin failures++; $display("FAIL mem_wbrd got=%h exp=%h", wb_rd, e[3:0]); end
  endtask

  task automatic test_fwd_wb();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd2, 1, 1, 4'd3, 1, 0);            // ADD R3
    tick();
    ex_alu_out = 16'h0055; nop();
    tick();
    ex_alu_out = 16'h0000;
    drive(1, 4'd3, 4'd3, 1, 1, 4'd4, 1, 0);            // SUB R4,R3,R3
    sb.push_back(16'(FWD_WB)); sb.push_back(16'(FWD_WB)); sb.push_back(16'h0055);
    sb.push_back(16'h1); sb.push_back(16'h3);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL wb_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL wb_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL wb_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL wb_wbwrite got=%b exp=%b", wb_write, e[0]); end
    e = sb.pop_front(); checks++; if (wb_rd !== e[3:0]) begin failures++; $display("FAIL wb_wbrd got=%h exp=%h", wb_rd, e[3:0]); end
    nop(); tick();
  endtask

  task automatic test_load_use();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd0, 1, 0, 4'd2, 1, 1);            // LW R2
    tick();
    ex_alu_out = 16'h0100;
    drive(1, 4'd2, 4'd1, 1, 1, 4'd6, 1, 0);            // ADD R6,R2,R1
    sb.push_back(16'h1);
    #1;
    e = sb.pop_front(); checks++; if (hazard_stall !== e[0]) begin failures++; $display("FAIL lu_stall got=%b exp=%b", hazard_stall, e[0]); end
    sb.push_back(16'(FWD_NONE)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'h0); sb.push_back(16'h0100);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL lu_bubble_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL lu_bubble_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (hazard_stall !== e[0]) begin failures++; $display("FAIL lu_one_cycle got=%b exp=%b", hazard_stall, e[0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL lu_faddr got=%h exp=%h", MEM_faddress, e); end
    mem_rdata = 16'hBEEF; ex_alu_out = 16'h0000;
    sb.push_back(16'(FWD_WB)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'hBEEF);
    sb.push_back(16'h1); sb.push_back(16'h2);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL lu_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL lu_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL lu_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL lu_wbwrite got=%b exp=%b", wb_write, e[0]); end
    e = sb.pop_front(); checks++; if (wb_rd !== e[3:0]) begin failures++; $display("FAIL lu_wbrd got=%h exp=%h", wb_rd, e[3:0]); end
    mem_rdata = '0; nop(); tick();
  endtask

  task automatic test_r0();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd2, 1, 1, 4'd0, 1, 0);            // ADD R0
    tick();
    ex_alu_out = 16'h7777;
    drive(1, 4'd0, 4'd0, 1, 1, 4'd4, 1, 0);            // SUB R4,R0,R0
    sb.push_back(16'(FWD_NONE)); sb.push_back(16'(FWD_NONE));
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL r0_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL r0_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    nop(); sb.push_back(16'h0);
    tick();
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL r0_wbwrite got=%b exp=%b", wb_write, e[0]); end
  endtask

  task automatic test_flush();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd0, 1, 0, 4'd2, 1, 1);            // LW R2
    tick();
    drive(1, 4'd2, 4'd2, 1, 1, 4'd6, 1, 0); flush = 1'b1;
    sb.push_back(16'h0);
    #1;
    e = sb.pop_front(); checks++; if (hazard_stall !== e[0]) begin failures++; $display("FAIL flush_stall got=%b exp=%b", hazard_stall, e[0]); end
    sb.push_back(16'(FWD_NONE));
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL flush_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    flush = 1'b0; nop();
    sb.push_back(16'h1); sb.push_back(16'h0);
    tick();
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL flush_load_wb got=%b exp=%b", wb_write, e[0]); end
    tick();
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL flush_squashed_wb got=%b exp=%b", wb_write, e[0]); end
  endtask

  task automatic test_stall_in();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd2, 1, 1, 4'd3, 1, 0);            // ADD R3
    tick();
    ex_alu_out = 16'h1111;
    drive(1, 4'd3, 4'd5, 1, 1, 4'd4, 1, 0);            // SUB R4,R3,R5
    sb.push_back(16'(FWD_MEM)); sb.push_back(16'h1111); sb.push_back(16'h0);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL st_pre_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL st_pre_faddr got=%h exp=%h", MEM_faddress, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL st_pre_wbwrite got=%b exp=%b", wb_write, e[0]); end
    stall_in = 1'b1; ex_alu_out = 16'h2222; mem_rdata = 16'hDEAD;
    drive(1, 4'd4, 4'd4, 1, 1, 4'd7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(16'(FWD_MEM)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'h1111); sb.push_back(16'h0);
      tick();
      e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL st_hold_fwdA[%0d] got=%b exp=%b", i, ForwardA, e[1:0]); end
      e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL st_hold_fwdB[%0d] got=%b exp=%b", i, ForwardB, e[1:0]); end
      e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL st_hold_faddr[%0d] got=%h exp=%h", i, MEM_faddress, e); end
      e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL st_hold_wbwrite[%0d] got=%b exp=%b", i, wb_write, e[0]); end
    end
    stall_in = 1'b0; mem_rdata = '0; nop();
    sb.push_back(16'h1111); sb.push_back(16'h1); sb.push_back(16'h3);
    sb.push_back(16'h2222); sb.push_back(16'(FWD_NONE));
    tick();
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL st_post_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL st_post_wbwrite got=%b exp=%b", wb_write, e[0]); end
    e = sb.pop_front(); checks++; if (wb_rd !== e[3:0]) begin failures++; $display("FAIL st_post_wbrd got=%h exp=%h", wb_rd, e[3:0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL st_post_faddr got=%h exp=%h", MEM_faddress, e); end
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL st_post_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] e;
    drain_pipe();
    drive(1, 4'd1, 4'd2, 1, 1, 4'd3, 1, 0);            // ADD R3
    tick();
    ex_alu_out = 16'hAAAA;
    drive(1, 4'd1, 4'd2, 1, 1, 4'd5, 1, 0);            // ADD R5
    tick();
    ex_alu_out = 16'hBBBB;
    drive(1, 4'd3, 4'd5, 1, 1, 4'd6, 1, 0);            // consumer of both
    rst = 1'b1;
    sb.push_back(16'(FWD_NONE)); sb.push_back(16'(FWD_NONE)); sb.push_back(16'h0);
    sb.push_back(16'h0); sb.push_back(16'h0);
    tick();
    e = sb.pop_front(); checks++; if (ForwardA !== e[1:0]) begin failures++; $display("FAIL mr_fwdA got=%b exp=%b", ForwardA, e[1:0]); end
    e = sb.pop_front(); checks++; if (ForwardB !== e[1:0]) begin failures++; $display("FAIL mr_fwdB got=%b exp=%b", ForwardB, e[1:0]); end
    e = sb.pop_front(); checks++; if (MEM_faddress !== e) begin failures++; $display("FAIL mr_faddr got=%h exp=%h", MEM_faddress, e); end
    e = sb.pop_front(); checks++; if (WB_fdata !== e) begin failures++; $display("FAIL mr_wbdata got=%h exp=%h", WB_fdata, e); end
    e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL mr_wbwrite got=%b exp=%b", wb_write, e[0]); end
    rst = 1'b0; nop(); ex_alu_out = '0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(16'h0);
      tick();
      e = sb.pop_front(); checks++; if (wb_write !== e[0]) begin failures++; $display("FAIL mr_no_wb[%0d] got=%b exp=%b", i, wb_write, e[0]); end
    end
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0; nop();
    ex_alu_out = '0; mem_rdata = '0;
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_load_use();
    test_r0();
    test_flush();
    test_stall_in();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
